boot_seq_ctrl: RTL
==================

# boot_seq_ctrl

Parametrised boot/IO sequencer replacing the fixed program/data loader FSM in `core/boot`. It loads `NSEG` memory segments over the UART/AXI byte path, sending a distinct handshake byte before each segment. It then runs the core and streams `result_words` words back out. Unlike the previous FSM, it generates the memory addresses, drains the FIFO before each phase change, and owns the result write-back loop.

## Interface
- `ADDRW`, 12: memory word-address width.
- `NSEG`, 2: number of load segments (seg 0 = program, last seg = data/result memory); ≥1.
- `ACK_BASE`, 8'h99: handshake byte for seg 0.
- `ACK_STEP`, 8'h11: handshake byte for seg k = ACK_BASE + k*ACK_STEP, mod 256.
- `BRAM_LAT`, 2: FIFO and memory read latency in cycles; ≥1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `mem_init_done` in 1: memory initialisation complete.
- `axi_w_success` in 1: one-cycle pulse, byte write accepted.
- `axi_w_busy` in 1: write path busy.
- `axi_r_success` in 1: one-cycle pulse, byte received.
- `axi_r_timeout` in 1: receive idle timeout; ends a segment.
- `axi_rdata` in 8: received byte; used only with `BOOT_CHECKSUM_EN`.
- `concat_valid` in 1: full memory word assembled.
- `fifo_empty` in 1: FIFO empty.
- `core_exec_done` in 1: core finished.
- `result_words` in ADDRW+1: number of result words to send; sampled on `core_exec_done`.
- `deconcat_done` in 1: one-cycle pulse, all bytes of the current word sent.
- `axi_we`, `axi_re` out 1: AXI write and read enables.
- `axi_wsel` out 1: write source; 0 = `axi_wdata`, 1 = deconcat.
- `axi_wdata` out 8: handshake or checksum byte.
- `concat_en`, `fifo_we`, `fifo_re` out 1.
- `mem_we`, `mem_re` out 1.
- `mem_seg` out max(1,$clog2(NSEG)): target segment.
- `mem_addr` out ADDRW: word address.
- `core_clk_en` out 1.
- `deconcat_en` out 1.
- `addr_ovf` out 1: sticky; a segment exceeded 2^ADDRW words.
- `done` out 1: sequence complete.

## Operation
- States: INIT, ACK, RECV, DRAIN, EXEC, RES_RD, RES_SEND, CSUM (macro only), DONE.
- State, segment index `seg`, address counter `addr`, read pointer `rptr`, latency counter, empty-delay pipe and checksum are registers.
- Outputs are combinational from the registers plus the inputs named below.

State behaviour:
- **INIT:** all enables 0. Go to ACK with `seg`=0 when `mem_init_done`=1.
- **ACK:**
  - Outputs: `axi_we`=1, `axi_wsel`=0, `axi_wdata`=ACK_BASE+seg*ACK_STEP.
  - On `axi_w_success`: clear `addr` and go to RECV.
- **RECV:**
  - Outputs: `axi_re`=1, `fifo_re`=1, `concat_en`=`axi_r_success`, `fifo_we`=`concat_valid`.
  - `fifo_empty` is delayed BRAM_LAT cycles through a pipe that resets to all 1s. The delayed value is `empty_d`.
  - `mem_we`=~`empty_d`, `mem_seg`=`seg`, `mem_addr`=`addr`.
  - `addr` increments after each `mem_we` cycle. On wrap from all 1s to 0, set `addr_ovf`; the address wraps.
  - On `axi_r_timeout`: go to DRAIN.
- **DRAIN:**
  - Outputs: `axi_re`=0, `concat_en`=0, `fifo_re`=1. `mem_we` behaves as in RECV.
  - Exit when every stage of the empty pipe and `fifo_empty` are all 1.
  - Exit target: if `seg`<NSEG-1, increment `seg` and go to ACK; otherwise go to EXEC.
- **EXEC:**
  - `core_clk_en`=1.
  - On `core_exec_done`: latch `result_words`, clear `rptr`.
  - Next state: RES_RD if the latched count ≠0; otherwise CSUM (with macro) or DONE.
- **RES_RD:**
  - `mem_re`=1, `mem_seg`=NSEG-1, `mem_addr`=`rptr`.
  - Stay exactly BRAM_LAT cycles, then go to RES_SEND.
- **RES_SEND:**
  - `axi_wsel`=1.
  - `deconcat_en` is a single-cycle pulse on the first cycle of the state in which `axi_w_busy`=0. It is never re-issued for the same word.
  - On `deconcat_done`: increment `rptr`. If `rptr`+1 == count, go to CSUM/DONE; otherwise go to RES_RD.
- **DONE:** `done`=1, all enables 0. Held until `rst`.

Boundary and reset behaviour:
- `rst` mid-sequence aborts to INIT and clears `seg`, `addr`, `rptr`, `addr_ovf`, checksum and the latency counter. The empty pipe is set to all 1s.
- Simultaneous `axi_r_timeout` and `axi_r_success` in RECV: the byte is still concatenated, then the FSM moves to DRAIN.
- `axi_w_success` outside ACK/CSUM is ignored.

## Timing
- Reset values: every output 0. `mem_addr`=0, `mem_seg`=0, `axi_wdata`=ACK_BASE.
- INIT→ACK: 1 cycle after `mem_init_done`. `axi_we` rises in the first ACK cycle.
- FIFO pop → `mem_we`: exactly BRAM_LAT cycles after a `fifo_re` cycle with `fifo_empty`=0.
- DRAIN lasts at least BRAM_LAT+1 cycles.
- `core_clk_en` is high for every EXEC cycle, including the `core_exec_done` cycle, and 0 afterwards.
- Per result word: BRAM_LAT cycles in RES_RD, plus the wait for `axi_w_busy`=0, plus the deconcat duration.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - An 8-bit modulo-256 sum accumulates `axi_rdata` on every `axi_r_success` cycle in RECV, across all segments.
  - After the last result word (or a zero count), CSUM state drives `axi_we`=1, `axi_wsel`=0, `axi_wdata`=sum until `axi_w_success`, then goes to DONE.
- Undefined: no CSUM state; `axi_rdata` is ignored; the sequence goes directly to DONE.

## Test plan
- NSEG=2, `mem_init_done` at cycle 5 → `axi_wdata`=8'h99 in ACK; after 8 bytes/2 words and a timeout, `mem_we` at addr 0,1 with seg 0; then `axi_wdata`=8'haa.
- Timeout asserted while 3 words are still in the FIFO → all 3 written (addr 0..2) before the next ACK. No `mem_we` occurs in ACK.
- `core_exec_done` with `result_words`=3 → `mem_re` at addr 0,1,2 on seg 1. Three `deconcat_en` pulses, each delayed while `axi_w_busy`=1. `done`=1 after the third `deconcat_done`.
- `result_words`=0 → EXEC goes directly to DONE (or CSUM); no `mem_re`.
- ADDRW=2 with 5 words loaded → addresses 0,1,2,3,0 and `addr_ovf`=1. `rst` pulse mid-RES_SEND → INIT with all outputs 0.
- `BOOT_CHECKSUM_EN` with bytes 8'hF0, 8'h20 → CSUM sends 8'h10.

Source files
------------

// File: rtl/boot_seq_ctrl.sv
// rtl/boot_seq_ctrl.sv - parametrised boot loader / result write-back sequencer
//
// Loads NSEG memory segments over the byte path. Each segment is preceded by
// a handshake byte ACK_BASE + seg*ACK_STEP. After loading, the sequencer runs
// the core and streams result words back out through the deconcatenator.
// The sequencer generates the memory addresses itself. It drains the FIFO
// before every phase change, and it owns the result write-back loop.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   Adds a modulo-256 sum of every received byte. The sum is sent as a final
//   byte (CSUM state) before DONE.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   mem_init_done          memory initialisation complete
//   axi_w_success/busy     byte write accepted pulse / write path busy
//   axi_r_success/timeout  byte received pulse / receive idle timeout
//   axi_rdata              received byte (checksum only)
//   concat_valid           full memory word assembled
//   fifo_empty             FIFO empty flag
//   core_exec_done         core finished
//   result_words           result word count, sampled on core_exec_done
//   deconcat_done          all bytes of the current result word sent
//   axi_we/axi_re          AXI write / read enables
//   axi_wsel               write source: 0 = axi_wdata, 1 = deconcatenator
//   axi_wdata              handshake or checksum byte
//   concat_en, fifo_we, fifo_re, mem_we, mem_re   datapath enables
//   mem_seg, mem_addr      target segment and word address
//   core_clk_en            core clock enable
//   deconcat_en            start-deconcatenation pulse
//   addr_ovf               sticky: a segment overflowed the address space
//   done                   sequence complete
module boot_seq_ctrl #(
    parameter int         ADDRW    = 12,
    parameter int         NSEG     = 2,
    parameter logic [7:0] ACK_BASE = 8'h99,
    parameter logic [7:0] ACK_STEP = 8'h11,
    parameter int         BRAM_LAT = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  mem_init_done,
    input  logic                                  axi_w_success,
    input  logic                                  axi_w_busy,
    input  logic                                  axi_r_success,
    input  logic                                  axi_r_timeout,
    input  logic [7:0]                            axi_rdata,
    input  logic                                  concat_valid,
    input  logic                                  fifo_empty,
    input  logic                                  core_exec_done,
    input  logic [ADDRW:0]                        result_words,
    input  logic                                  deconcat_done,
    output logic                                  axi_we,
    output logic                                  axi_re,
    output logic                                  axi_wsel,
    output logic [7:0]                            axi_wdata,
    output logic                                  concat_en,
    output logic                                  fifo_we,
    output logic                                  fifo_re,
    output logic                                  mem_we,
    output logic                                  mem_re,
    output logic [((NSEG > 1) ? $clog2(NSEG) : 1)-1:0] mem_seg,
    output logic [ADDRW-1:0]                      mem_addr,
    output logic                                  core_clk_en,
    output logic                                  deconcat_en,
    output logic                                  addr_ovf,
    output logic                                  done
);
    localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int LATW = $clog2(BRAM_LAT + 1) + 1;

    typedef enum logic [3:0] {
        S_INIT,
        S_ACK,
        S_RECV,
        S_DRAIN,
        S_EXEC,
        S_RES_RD,
        S_RES_SEND,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam state_t S_FINAL = S_CSUM;
`else
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t               state_q, state_d;
    logic [SEGW-1:0]      seg_q, seg_d;
    logic [ADDRW-1:0]     addr_q, addr_d;
    logic [ADDRW:0]       rptr_q, rptr_d;
    logic [ADDRW:0]       cnt_q, cnt_d;
    logic [LATW-1:0]      lat_q, lat_d;
    logic [BRAM_LAT-1:0]  pipe_q, pipe_d;
    logic                 ovf_q, ovf_d;
    logic                 issued_q, issued_d;
    logic [7:0]           csum_q, csum_d;
    logic                 empty_d;
    logic [7:0]           ack_byte;
    logic [ADDRW:0]       rptr_inc;

`ifndef BOOT_CHECKSUM_EN
    logic unused_rdata;
    assign unused_rdata = ^axi_rdata;
`endif

    // The pipe tracks "no pop happened" so that a popped FIFO entry shows up
    // as a write exactly BRAM_LAT cycles later, matching the FIFO read latency.
    assign empty_d  = pipe_q[BRAM_LAT-1];
    assign ack_byte = ACK_BASE + 8'(seg_q) * ACK_STEP;
    assign rptr_inc = rptr_q + (ADDRW+1)'(1);
    assign addr_ovf = ovf_q;

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        addr_d      = addr_q;
        rptr_d      = rptr_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        ovf_d       = ovf_q;
        issued_d    = issued_q;
        csum_d      = csum_q;
        axi_we      = 1'b0;
        axi_re      = 1'b0;
        axi_wsel    = 1'b0;
        axi_wdata   = ack_byte;
        concat_en   = 1'b0;
        fifo_we     = 1'b0;
        fifo_re     = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_seg     = '0;
        mem_addr    = '0;
        core_clk_en = 1'b0;
        deconcat_en = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_INIT: begin
                if (mem_init_done) begin
                    seg_d   = '0;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                axi_we = 1'b1;
                if (axi_w_success) begin
                    addr_d  = '0;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                axi_re    = 1'b1;
                fifo_re   = 1'b1;
                concat_en = axi_r_success;
                fifo_we   = concat_valid;
                mem_we    = ~empty_d;
                mem_seg   = seg_q;
                mem_addr  = addr_q;
`ifdef BOOT_CHECKSUM_EN
                if (axi_r_success) csum_d = csum_q + axi_rdata;
`endif
                if (axi_r_timeout) begin
                    lat_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A word completing right at the timeout still reaches the FIFO.
                fifo_re  = 1'b1;
                fifo_we  = concat_valid;
                mem_we   = ~empty_d;
                mem_seg  = seg_q;
                mem_addr = addr_q;
                if (lat_q < LATW'(BRAM_LAT)) lat_d = lat_q + LATW'(1);
                if ((lat_q >= LATW'(BRAM_LAT)) && (&pipe_q) && fifo_empty && !concat_valid) begin
                    if (seg_q < SEGW'(NSEG - 1)) begin
                        seg_d   = seg_q + SEGW'(1);
                        state_d = S_ACK;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                core_clk_en = 1'b1;
                if (core_exec_done) begin
                    cnt_d    = result_words;
                    rptr_d   = '0;
                    lat_d    = '0;
                    issued_d = 1'b0;
                    state_d  = (result_words != '0) ? S_RES_RD : S_FINAL;
                end
            end
            S_RES_RD: begin
                mem_re   = 1'b1;
                mem_seg  = SEGW'(NSEG - 1);
                mem_addr = rptr_q[ADDRW-1:0];
                if (lat_q == LATW'(BRAM_LAT - 1)) state_d = S_RES_SEND;
                else lat_d = lat_q + LATW'(1);
            end
            S_RES_SEND: begin
                axi_wsel    = 1'b1;
                deconcat_en = ~axi_w_busy & ~issued_q;
                if (deconcat_en) issued_d = 1'b1;
                if (deconcat_done) begin
                    rptr_d   = rptr_inc;
                    issued_d = 1'b0;
                    lat_d    = '0;
                    state_d  = (rptr_inc == cnt_q) ? S_FINAL : S_RES_RD;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                axi_we    = 1'b1;
                axi_wdata = csum_q;
                if (axi_w_success) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                done = 1'b1;
            end
            default: state_d = S_INIT;
        endcase

        if (mem_we) begin
            addr_d = addr_q + ADDRW'(1);
            if (&addr_q) ovf_d = 1'b1;
        end

        pipe_d[0] = ~(fifo_re & ~fifo_empty);
        for (int i = 1; i < BRAM_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_INIT;
            seg_q    <= '0;
            addr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            lat_q    <= '0;
            pipe_q   <= '1;
            ovf_q    <= 1'b0;
            issued_q <= 1'b0;
            csum_q   <= '0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            addr_q   <= addr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            pipe_q   <= pipe_d;
            ovf_q    <= ovf_d;
            issued_q <= issued_d;
            csum_q   <= csum_d;
        end
    end
endmodule
